// File: rtl/snn_tick_scheduler.sv
`timescale 1ns/1ps
// snn_tick_scheduler
// Wishbone-controlled timestep sequencer for the 2-core SNN. The host programs
// a tick count and core enables, then pulses START. Each tick waits for IMEM to
// report that the input spikes are loaded. Every enabled core, in ascending
// order, is then scanned: integrate over all axons, fire, and capture into OMEM.
module snn_tick_scheduler #(
   parameter int          NUM_AXONS  = 256,
   parameter int          NUM_CORES  = 2,
   parameter logic [31:0] CSR_BASE   = 32'h80050000,
   parameter int          TICK_WIDTH = 16
) (
   input  logic                         wb_clk_i,
   input  logic                         wb_rst_i,
   input  logic                         wbs_cyc_i,
   input  logic                         wbs_stb_i,
   input  logic                         wbs_we_i,
   input  logic [3:0]                   wbs_sel_i,
   input  logic [31:0]                  wbs_adr_i,
   input  logic [31:0]                  wbs_dat_i,
   output logic                         wbs_ack_o,
   output logic [31:0]                  wbs_dat_o,
   input  logic                         spike_ready_i,
   output logic                         core_sel_o,
   output logic [$clog2(NUM_AXONS)-1:0] axon_idx_o,
   output logic                         integrate_en_o,
   output logic                         fire_en_o,
   output logic                         latch_spikes_o,
   output logic                         busy_o,
   output logic                         irq_o
);

   localparam int              AW         = $clog2(NUM_AXONS);
   localparam logic [AW-1:0]   LAST_AXON  = AW'(NUM_AXONS - 1);
   localparam logic [1:0]      OFF_CTRL   = 2'd0;
   localparam logic [1:0]      OFF_NTICKS = 2'd1;
   localparam logic [1:0]      OFF_STATUS = 2'd2;
   // Only the two-core arrangement is sequenced by this revision.
   localparam logic            CORES_OK   = (NUM_CORES == 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_IN,
      S_INTEGRATE,
      S_FIRE,
      S_CAPTURE,
      S_DONE
   } state_t;

   state_t                  state_q, state_d;
   logic                    core_sel_q, core_sel_d;
   logic [AW-1:0]           axon_idx_q, axon_idx_d;
   logic [TICK_WIDTH-1:0]   tick_cnt_q, tick_cnt_d;
   logic [TICK_WIDTH-1:0]   ntick_q, ntick_d;
   logic                    en0_q, en0_d;
   logic                    en1_q, en1_d;
   logic                    done_q, done_d;
   logic                    ack_q, ack_d;
   logic [31:0]             dat_q, dat_d;

   logic                    in_window;
   logic                    accept;
   logic                    wr;
   logic                    rd;
   logic                    busy;
   logic [1:0]              offset;
   logic                    wr_ctrl;
   logic                    start_req;
   logic                    abort_req;
   logic                    done_clr;
   logic                    done_set;
   logic                    done_restart;
   logic [TICK_WIDTH-1:0]   tick_inc;
   logic [15:0]             tick_status;
   logic [31:0]             rdata;
   logic                    unused_bits;

   // Bus decode: a request is accepted only when no ack is in flight, so a held
   // strobe yields an ack every other cycle.
   assign offset      = wbs_adr_i[3:2];
   assign in_window   = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:4] == CSR_BASE[31:4]);
   assign accept      = in_window && !ack_q;
   assign wr          = accept && wbs_we_i;
   assign rd          = accept && !wbs_we_i;
   assign wr_ctrl     = wr && (offset == OFF_CTRL) && wbs_sel_i[0];
   assign start_req   = wr_ctrl && wbs_dat_i[0];
   assign abort_req   = wr_ctrl && wbs_dat_i[1];
   assign done_clr    = wr && (offset == OFF_STATUS) && wbs_sel_i[0] && wbs_dat_i[1];
   assign busy        = (state_q == S_WAIT_IN) || (state_q == S_INTEGRATE) ||
                        (state_q == S_FIRE)    || (state_q == S_CAPTURE);
   assign tick_inc    = (&tick_cnt_q) ? tick_cnt_q : tick_cnt_q + TICK_WIDTH'(1);
   assign tick_status = 16'(tick_cnt_q);
   assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i, wbs_sel_i, CORES_OK};

   // Configuration registers: enables and tick count are frozen during a run.
   always_comb begin
      en0_d   = en0_q;
      en1_d   = en1_q;
      ntick_d = ntick_q;
      if (wr_ctrl && !busy) begin
         en0_d = wbs_dat_i[2];
         en1_d = wbs_dat_i[3];
      end
      if (wr && (offset == OFF_NTICKS) && !busy) begin
         for (int b = 0; b < TICK_WIDTH; b++) begin
            if (wbs_sel_i[b / 8]) begin
               ntick_d[b] = wbs_dat_i[b];
            end
         end
      end
   end

   // Read mux and single-cycle ack; read data is zero whenever no ack is driven.
   always_comb begin
      rdata = 32'd0;
      case (offset)
         OFF_CTRL:   rdata = {28'd0, en1_q, en0_q, 2'b00};
         OFF_NTICKS: rdata = 32'(ntick_q);
         OFF_STATUS: rdata = {tick_status, 14'd0, done_q, busy};
         default:    rdata = 32'd0;
      endcase
      ack_d = accept;
      dat_d = rd ? rdata : 32'd0;
   end

   // Sequencer next state: tick/core/axon walk, with ABORT overriding everything.
   always_comb begin
      state_d      = state_q;
      core_sel_d   = core_sel_q;
      axon_idx_d   = axon_idx_q;
      tick_cnt_d   = tick_cnt_q;
      done_set     = 1'b0;
      done_restart = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_req && !abort_req) begin
               tick_cnt_d = '0;
               if ((ntick_q != '0) && (en0_d || en1_d)) begin
                  state_d      = S_WAIT_IN;
                  core_sel_d   = !en0_d;
                  done_restart = 1'b1;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_WAIT_IN: begin
            if (spike_ready_i) begin
               state_d    = S_INTEGRATE;
               axon_idx_d = '0;
            end
         end
         S_INTEGRATE: begin
            axon_idx_d = axon_idx_q + AW'(1);
            if (axon_idx_q == LAST_AXON) begin
               state_d = S_FIRE;
            end
         end
         S_FIRE: begin
            state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            if (!core_sel_q && en1_q) begin
               // Second core reuses the inputs already loaded for this tick.
               core_sel_d = 1'b1;
               state_d    = S_INTEGRATE;
            end else begin
               tick_cnt_d = tick_inc;
               if (tick_inc == ntick_q) begin
                  state_d = S_DONE;
               end else begin
                  core_sel_d = !en0_q;
                  state_d    = S_WAIT_IN;
               end
            end
         end
         S_DONE: begin
            done_set = 1'b1;
            state_d  = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      if (abort_req && (state_q != S_IDLE)) begin
         state_d  = S_IDLE;
         done_set = 1'b0;
      end
      done_d = done_q;
      if (done_clr || done_restart) begin
         done_d = 1'b0;
      end
      if (done_set) begin
         done_d = 1'b1;
      end
   end

   // Sequencer and status state.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q    <= S_IDLE;
         core_sel_q <= 1'b0;
         axon_idx_q <= '0;
         tick_cnt_q <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         core_sel_q <= core_sel_d;
         axon_idx_q <= axon_idx_d;
         tick_cnt_q <= tick_cnt_d;
         done_q     <= done_d;
      end
   end

   // Bus response and configuration registers.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         ack_q   <= 1'b0;
         dat_q   <= 32'd0;
         en0_q   <= 1'b0;
         en1_q   <= 1'b0;
         ntick_q <= '0;
      end else begin
         ack_q   <= ack_d;
         dat_q   <= dat_d;
         en0_q   <= en0_d;
         en1_q   <= en1_d;
         ntick_q <= ntick_d;
      end
   end

   assign wbs_ack_o      = ack_q;
   assign wbs_dat_o      = dat_q;
   assign core_sel_o     = core_sel_q;
   assign axon_idx_o     = axon_idx_q;
   assign integrate_en_o = (state_q == S_INTEGRATE);
   assign fire_en_o      = (state_q == S_FIRE);
   assign latch_spikes_o = (state_q == S_CAPTURE);
   assign busy_o         = busy;
   assign irq_o          = done_q;

endmodule

// File: tb/tb_snn_tick_scheduler.sv
`timescale 1ns/1ps
// Bench for snn_tick_scheduler with an 8-axon configuration. Strobe events seen
// by the monitor are checked against an expected-event scoreboard.
module tb_snn_tick_scheduler;

   localparam int          NAX  = 8;
   localparam logic [31:0] BASE = 32'h80050000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [3:0]  sel = 4'h0;
   logic [31:0] adr = 32'd0, wdat = 32'd0;
   logic        ack;
   logic [31:0] rdat_o;
   logic        spike = 1'b0;
   logic        core_sel;
   logic [2:0]  axon_idx;
   logic        int_en, fire_en, latch_en, busy, irq;

   int vec_cnt = 0;
   int err_cnt = 0;
   int exp_q[$];
   int obs_q[$];
   int busy_cnt  = 0;
   int wait_cnt  = 0;
   int core0_cnt = 0;

   snn_tick_scheduler #(.NUM_AXONS(NAX)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
      .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat_o),
      .spike_ready_i(spike), .core_sel_o(core_sel), .axon_idx_o(axon_idx),
      .integrate_en_o(int_en), .fire_en_o(fire_en), .latch_spikes_o(latch_en),
      .busy_o(busy), .irq_o(irq)
   );

   always #5 clk = ~clk;

   // Monitor: event code = kind*256 + core*16 + axon (kind 1=int, 2=fire, 3=latch).
   always @(negedge clk) begin
      if (!rst) begin
         if (int_en)   obs_q.push_back(256 + 16 * int'(core_sel) + int'(axon_idx));
         if (fire_en)  obs_q.push_back(512 + 16 * int'(core_sel));
         if (latch_en) obs_q.push_back(768 + 16 * int'(core_sel));
         if (busy) busy_cnt++;
         if (busy && !int_en && !fire_en && !latch_en) wait_cnt++;
         if (busy && !core_sel) core0_cnt++;
      end
   end

   task automatic bus_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] r, output bit got);
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
      got = 1'b0; r = 32'd0;
      for (int i = 0; i < 4 && !got; i++) begin
         @(posedge clk); #1;
         if (ack) begin
            got = 1'b1;
            r = rdat_o;
         end
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   task automatic wait_irq(input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         @(posedge clk); #1;
         if (irq) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic push_core(input int c);
      for (int ax = 0; ax < NAX; ax++) exp_q.push_back(256 + 16 * c + ax);
      exp_q.push_back(512 + 16 * c);
      exp_q.push_back(768 + 16 * c);
   endtask

   task automatic test_reset();
      logic [31:0] r;
      bit a;
      int acks;
      logic [31:0] exp_rd [4];
      exp_rd = '{32'd0, 32'd0, 32'd0, 32'd0};
      repeat (3) @(posedge clk);
      #1;
      vec_cnt++;
      if ({ack, rdat_o, core_sel, axon_idx, int_en, fire_en, latch_en, busy, irq} !== '0) begin
         err_cnt++;
         $display("FAIL reset_outputs: got ack=%b dat=%h core=%b axon=%0d int=%b fire=%b latch=%b busy=%b irq=%b, want all 0",
                  ack, rdat_o, core_sel, axon_idx, int_en, fire_en, latch_en, busy, irq);
      end
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         bus_xfer(1'b0, BASE + 32'(4 * k), 32'd0, 4'hF, r, a);
         vec_cnt++;
         if (!a || r !== exp_rd[k]) begin
            err_cnt++;
            $display("FAIL reset_read_off%0h: ack=%b data=%h, want ack=1 data=%h", 4 * k, a, r, exp_rd[k]);
         end
      end
      bus_xfer(1'b0, BASE + 32'h10, 32'd0, 4'hF, r, a);
      vec_cnt++;
      if (a || rdat_o !== 32'd0) begin
         err_cnt++;
         $display("FAIL out_of_window: ack=%b dat=%h, want ack=0 dat=0", a, rdat_o);
      end
      // Held strobe: acks must alternate 1,0,1,0.
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h8; sel = 4'hF;
      acks = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         acks = acks * 2 + int'(ack);
      end
      cyc = 1'b0; stb = 1'b0;
      vec_cnt++;
      if (acks !== 10) begin
         err_cnt++;
         $display("FAIL held_stb_ack_pattern: got %b, want 1010", acks[3:0]);
      end
      $display("test_reset done");
   endtask

   task automatic test_two_ticks();
      logic [31:0] r;
      bit a, ok;
      int e, o;
      spike = 1'b1;
      bus_xfer(1'b1, BASE + 32'h4, 32'd2, 4'hF, r, a);
      exp_q.delete(); obs_q.delete(); busy_cnt = 0;
      for (int t = 0; t < 2; t++) begin
         push_core(0);
         push_core(1);
      end
      bus_xfer(1'b1, BASE, 32'hD, 4'hF, r, a);
      wait_irq(300, ok);
      vec_cnt++;
      if (!ok) begin err_cnt++; $display("FAIL two_ticks_irq: irq never rose within bound"); end
      vec_cnt++;
      if (obs_q.size() != exp_q.size()) begin
         err_cnt++;
         $display("FAIL two_ticks_event_count: got %0d, want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
         vec_cnt++;
         if (o !== e) begin err_cnt++; $display("FAIL two_ticks_event: got %h, want %h", o, e); end
      end
      vec_cnt++;
      if (busy_cnt != 42) begin err_cnt++; $display("FAIL two_ticks_busy_cycles: got %0d, want 42", busy_cnt); end
      bus_xfer(1'b0, BASE + 32'h8, 32'd0, 4'hF, r, a);
      vec_cnt++;
      if (!a || r !== 32'h0002_0002 || irq !== 1'b1) begin
         err_cnt++;
         $display("FAIL two_ticks_status: ack=%b status=%h irq=%b, want 1 00020002 1", a, r, irq);
      end
      $display("test_two_ticks done");
   endtask

   task automatic test_wait_core1();
      logic [31:0] r;
      bit a, ok;
      int e, o;
      spike = 1'b0;
      bus_xfer(1'b1, BASE + 32'h4, 32'd1, 4'hF, r, a);
      exp_q.delete(); obs_q.delete(); busy_cnt = 0; wait_cnt = 0; core0_cnt = 0;
      push_core(1);
      bus_xfer(1'b1, BASE, 32'h9, 4'hF, r, a);
      repeat (4) @(posedge clk);
      #1;
      spike = 1'b1;
      wait_irq(100, ok);
      vec_cnt++;
      if (!ok) begin err_cnt++; $display("FAIL core1_irq: irq never rose within bound"); end
      vec_cnt++;
      if (wait_cnt != 5) begin err_cnt++; $display("FAIL core1_wait_cycles: got %0d, want 5", wait_cnt); end
      vec_cnt++;
      if (core0_cnt != 0) begin err_cnt++; $display("FAIL core1_core_sel: got %0d busy cycles on core 0, want 0", core0_cnt); end
      vec_cnt++;
      if (busy_cnt != 15) begin err_cnt++; $display("FAIL core1_busy_cycles: got %0d, want 15", busy_cnt); end
      vec_cnt++;
      if (obs_q.size() != exp_q.size()) begin
         err_cnt++;
         $display("FAIL core1_event_count: got %0d, want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
         vec_cnt++;
         if (o !== e) begin err_cnt++; $display("FAIL core1_event: got %h, want %h", o, e); end
      end
      bus_xfer(1'b0, BASE + 32'h8, 32'd0, 4'hF, r, a);
      vec_cnt++;
      if (r !== 32'h0001_0002) begin err_cnt++; $display("FAIL core1_status: got %h, want 00010002", r); end
      $display("test_wait_core1 done");
   endtask

   task automatic test_abort();
      logic [31:0] r;
      bit a, hit;
      int e, o;
      spike = 1'b1;
      bus_xfer(1'b1, BASE + 32'h4, 32'd3, 4'hF, r, a);
      exp_q.delete(); obs_q.delete();
      for (int ax = 0; ax < 4; ax++) exp_q.push_back(256 + ax);
      bus_xfer(1'b1, BASE, 32'hD, 4'hF, r, a);
      hit = 1'b0;
      for (int i = 0; i < 50 && !hit; i++) begin
         @(posedge clk); #1;
         if (int_en && axon_idx == 3'd2) hit = 1'b1;
      end
      vec_cnt++;
      if (!hit) begin err_cnt++; $display("FAIL abort_reach_axon2: integrate never reached axon 2"); end
      // The write is accepted on the edge that ends the axon-3 cycle.
      bus_xfer(1'b1, BASE, 32'hE, 4'hF, r, a);
      vec_cnt++;
      if ({int_en, fire_en, latch_en, busy} !== 4'b0000) begin
         err_cnt++;
         $display("FAIL abort_strobes: got int=%b fire=%b latch=%b busy=%b, want 0000", int_en, fire_en, latch_en, busy);
      end
      repeat (5) @(posedge clk);
      vec_cnt++;
      if (obs_q.size() != exp_q.size()) begin
         err_cnt++;
         $display("FAIL abort_event_count: got %0d, want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
         vec_cnt++;
         if (o !== e) begin err_cnt++; $display("FAIL abort_event: got %h, want %h", o, e); end
      end
      bus_xfer(1'b0, BASE + 32'h8, 32'd0, 4'hF, r, a);
      vec_cnt++;
      if (r !== 32'h0 || irq !== 1'b0) begin err_cnt++; $display("FAIL abort_status: got %h irq=%b, want 00000000 0", r, irq); end
      // START together with ABORT: no run begins.
      obs_q.delete();
      bus_xfer(1'b1, BASE, 32'hF, 4'hF, r, a);
      repeat (4) @(posedge clk);
      #1;
      vec_cnt++;
      if (busy !== 1'b0 || obs_q.size() != 0) begin
         err_cnt++;
         $display("FAIL start_abort_same_write: busy=%b events=%0d, want 0 0", busy, obs_q.size());
      end
      $display("test_abort done");
   endtask

   task automatic test_zero_and_w1c();
      logic [31:0] r;
      bit a, ok;
      bus_xfer(1'b1, BASE + 32'h4, 32'd0, 4'hF, r, a);
      obs_q.delete(); busy_cnt = 0;
      bus_xfer(1'b1, BASE, 32'hD, 4'hF, r, a);
      wait_irq(10, ok);
      repeat (2) @(posedge clk);
      #1;
      vec_cnt++;
      if (!ok || obs_q.size() != 0 || busy_cnt != 0) begin
         err_cnt++;
         $display("FAIL zero_ticks: irq=%b events=%0d busy_cycles=%0d, want 1 0 0", ok, obs_q.size(), busy_cnt);
      end
      bus_xfer(1'b0, BASE + 32'h8, 32'd0, 4'hF, r, a);
      vec_cnt++;
      if (r !== 32'h2) begin err_cnt++; $display("FAIL zero_ticks_status: got %h, want 00000002", r); end
      bus_xfer(1'b1, BASE + 32'h8, 32'h2, 4'hF, r, a);
      bus_xfer(1'b0, BASE + 32'h8, 32'd0, 4'hF, r, a);
      vec_cnt++;
      if (r !== 32'h0 || irq !== 1'b0) begin err_cnt++; $display("FAIL w1c_done: status=%h irq=%b, want 00000000 0", r, irq); end
      // Non-zero tick count but no core enabled also completes at once.
      bus_xfer(1'b1, BASE + 32'h4, 32'd3, 4'hF, r, a);
      obs_q.delete(); busy_cnt = 0;
      bus_xfer(1'b1, BASE, 32'h1, 4'hF, r, a);
      wait_irq(10, ok);
      vec_cnt++;
      if (!ok || obs_q.size() != 0 || busy_cnt != 0) begin
         err_cnt++;
         $display("FAIL no_core_enabled: irq=%b events=%0d busy_cycles=%0d, want 1 0 0", ok, obs_q.size(), busy_cnt);
      end
      $display("test_zero_and_w1c done");
   endtask

   task automatic test_busy_writes();
      logic [31:0] r;
      bit a, ok;
      int e, o;
      spike = 1'b1;
      bus_xfer(1'b1, BASE + 32'h4, 32'd2, 4'hF, r, a);
      exp_q.delete(); obs_q.delete(); busy_cnt = 0;
      push_core(0);
      push_core(0);
      bus_xfer(1'b1, BASE, 32'h5, 4'hF, r, a);
      bus_xfer(1'b1, BASE + 32'h4, 32'd5, 4'hF, r, a);
      vec_cnt++;
      if (!a) begin err_cnt++; $display("FAIL busy_write_ack: ack=0, want 1"); end
      bus_xfer(1'b1, BASE, 32'hC, 4'hF, r, a);
      bus_xfer(1'b0, BASE + 32'h4, 32'd0, 4'hF, r, a);
      vec_cnt++;
      if (r !== 32'd2) begin err_cnt++; $display("FAIL busy_ntick_kept: got %h, want 00000002", r); end
      bus_xfer(1'b0, BASE, 32'd0, 4'hF, r, a);
      vec_cnt++;
      if (r !== 32'h4 || busy !== 1'b1) begin err_cnt++; $display("FAIL busy_ctrl_kept: ctrl=%h busy=%b, want 00000004 1", r, busy); end
      wait_irq(200, ok);
      vec_cnt++;
      if (!ok || busy_cnt != 22) begin
         err_cnt++;
         $display("FAIL busy_run_length: irq=%b busy_cycles=%0d, want 1 22", ok, busy_cnt);
      end
      vec_cnt++;
      if (obs_q.size() != exp_q.size()) begin
         err_cnt++;
         $display("FAIL busy_event_count: got %0d, want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
         vec_cnt++;
         if (o !== e) begin err_cnt++; $display("FAIL busy_event: got %h, want %h", o, e); end
      end
      bus_xfer(1'b0, BASE + 32'h8, 32'd0, 4'hF, r, a);
      vec_cnt++;
      if (r !== 32'h0002_0002) begin err_cnt++; $display("FAIL busy_status: got %h, want 00020002", r); end
      $display("test_busy_writes done");
   endtask

   task automatic test_reset_midrun();
      logic [31:0] r;
      bit a, hit;
      bus_xfer(1'b1, BASE + 32'h4, 32'd1, 4'hF, r, a);
      bus_xfer(1'b1, BASE, 32'h5, 4'hF, r, a);
      hit = 1'b0;
      for (int i = 0; i < 20 && !hit; i++) begin
         @(posedge clk); #1;
         if (int_en) hit = 1'b1;
      end
      #2 rst = 1'b1;
      #1;
      vec_cnt++;
      if (!hit || {int_en, fire_en, latch_en, busy, core_sel, axon_idx} !== '0) begin
         err_cnt++;
         $display("FAIL reset_midrun_outputs: started=%b int=%b fire=%b latch=%b busy=%b axon=%0d, want 1 and all 0",
                  hit, int_en, fire_en, latch_en, busy, axon_idx);
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      obs_q.delete();
      repeat (20) @(posedge clk);
      bus_xfer(1'b0, BASE + 32'h4, 32'd0, 4'hF, r, a);
      vec_cnt++;
      if (obs_q.size() != 0 || r !== 32'd0) begin
         err_cnt++;
         $display("FAIL reset_midrun_quiet: events=%0d ntick=%h, want 0 00000000", obs_q.size(), r);
      end
      $display("test_reset_midrun done");
   endtask

   initial begin
      test_reset();
      test_two_ticks();
      test_wait_core1();
      test_abort();
      test_zero_and_w1c();
      test_busy_writes();
      test_reset_midrun();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/snn_tick_scheduler.md
Name: snn_tick_scheduler

Overview:
- Wishbone-controlled timestep sequencer for the 2-core SNN.
- Once the host has loaded input spikes, it runs a programmed number of ticks. Each tick covers each enabled core in order: scan all axons (integrate), fire, then capture output spikes into OMEM.
- Sits beside the address decoder. It drives the core-select, axon-index and enable strobes that the neuron blocks, IMEM and OMEM consume.

Parameters:
- NUM_AXONS, 256, axons scanned per core per tick (power of 2, ≥2)
- NUM_CORES, 2, cores sequenced (fixed at 2 in this revision)
- CSR_BASE, 32'h80050000, base byte address of the control registers
- TICK_WIDTH, 16, width of the tick count and tick counter

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  asynchronous active-high reset
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_stb_i  in  1  Wishbone strobe
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte lanes
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- spike_ready_i  in  1  IMEM reports the current tick's input spikes are loaded
- core_sel_o  out  1  core being processed
- axon_idx_o  out  $clog2(NUM_AXONS)  axon being integrated
- integrate_en_o  out  1  neurons of core_sel_o accumulate axon axon_idx_o this cycle
- fire_en_o  out  1  threshold/reset evaluation strobe for core_sel_o
- latch_spikes_o  out  1  OMEM captures spike vector of core_sel_o
- busy_o  out  1  run in progress
- irq_o  out  1  level interrupt; equals STATUS.done

Behaviour:
- Reset (async, wb_rst_i=1):
  - All outputs are 0.
  - FSM is IDLE; all CSRs are 0.
- CSR map (word offsets from CSR_BASE):
  - 0x0 CTRL:
    - bit0 START: write 1 pulses, reads 0.
    - bit1 ABORT: write 1 pulses, reads 0.
    - bit2 EN0: R/W.
    - bit3 EN1: R/W.
  - 0x4 NTICKS[TICK_WIDTH-1:0]: R/W.
  - 0x8 STATUS:
    - bit0 busy: RO.
    - bit1 done: sticky, write-1-to-clear.
    - [31:16] ticks completed: RO.
  - Other offsets in the 16-byte window read 0 and ignore writes.
- Bus handshake:
  - A request in the window is cyc&stb with adr[31:4]==CSR_BASE[31:4]. wbs_ack_o asserts exactly 1 cycle later, for 1 cycle.
  - No back-to-back ack: the next ack needs stb re-sampled after an ack cycle.
  - Outside the window: no ack; wbs_dat_o=0.
  - Writes honour wbs_sel_i per byte.
  - Writes to NTICKS, EN0 and EN1 while busy are ignored; they still ack.
- FSM states: IDLE, WAIT_IN, INTEGRATE, FIRE, CAPTURE, DONE.
- IDLE:
  - START with NTICKS≠0 and (EN0|EN1) goes to WAIT_IN. It clears the tick counter and done, and sets core_sel to the lowest enabled core.
  - START with NTICKS=0 or no core enabled goes straight to DONE: done is set, no strobes are issued.
- WAIT_IN: waits for spike_ready_i=1, then goes to INTEGRATE with axon_idx=0.
- INTEGRATE:
  - integrate_en_o=1 every cycle; axon_idx increments.
  - After axon_idx=NUM_AXONS-1, goes to FIRE. This is NUM_AXONS cycles; axon_idx_o wraps to 0.
- FIRE: fire_en_o=1 for 1 cycle, then CAPTURE.
- CAPTURE:
  - latch_spikes_o=1 for 1 cycle.
  - If another enabled core has a higher index, core_sel moves to it and goes to INTEGRATE. The same tick's input is still valid, so WAIT_IN is not re-entered.
  - Otherwise the tick counter increments. If counter==NTICKS, go to DONE. Else core_sel returns to the lowest enabled core and goes to WAIT_IN.
- DONE: sets done for 1 cycle in state, then IDLE. busy_o=1 from WAIT_IN through CAPTURE only.
- Timing: a tick with both cores enabled and spike_ready_i held high costs 1 + 2×(NUM_AXONS+2) cycles.
- ABORT (any non-IDLE state):
  - Next cycle goes to IDLE and deasserts all strobes.
  - done is not set; the tick counter keeps its partial value.
  - START and ABORT in the same write: ABORT wins.
- START while busy is ignored.
- Tick counter saturates at 2^TICK_WIDTH−1; it cannot be exceeded because NTICKS bounds it.
- The done clear (W1C) and a done set in the same cycle: set wins.
- Reset mid-run returns to IDLE immediately with no further strobes.

Test Plan:
1. Reset → CSR reads 0; all strobes 0. Read offset 0xC → 0 with ack. Access to CSR_BASE+0x10 → no ack.
2. NUM_AXONS=8, EN0=EN1=1, NTICKS=2, START, spike_ready_i=1:
   - Per tick: integrate_en 8 cycles with axon_idx 0..7 on core 0, fire, latch, then the same on core 1.
   - Total 2×(1+20)=42 busy cycles; STATUS=0x0002_0002 (done=1, ticks=2); irq_o=1.
3. EN1 only, NTICKS=1, spike_ready_i held low 5 cycles → WAIT_IN stalls 5 cycles; core_sel_o=1 throughout; no core-0 strobes.
4. ABORT written during INTEGRATE at axon_idx=3 → strobes drop the next cycle; busy=0, done=0.
5. Write 1 to STATUS bit1 → done/irq clear. START with NTICKS=0 → done=1, no strobes.
6. Write NTICKS=5 while busy with NTICKS=2 → ack given, value stays 2, run ends after 2 ticks.
